// File: rtl/systolic_pkg.sv
// Shared definitions for the 3x3 systolic feeder: FSM encoding, lane count
// and the index helpers used to pack/unpack lane vectors.
package systolic_pkg;

  localparam int LANES = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit offset of lane `lane` in a packed vector of `w`-bit elements.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  // Row-major element index inside a flattened LANES x LANES matrix.
  function automatic int elem_idx(input int row, input int col);
    return row * LANES + col;
  endfunction

endpackage

// File: rtl/feeder_buf.sv
// Storage for the A and B 3x3 matrices plus the per-row loaded mask.
// Matrices are exposed flattened row-major, element (r,c) at index r*3+c.
module feeder_buf
  import systolic_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic                            wr_sel,
  input  logic [1:0]                      wr_row,
  input  logic [LANES*DATA_W-1:0]         wr_data,
  output logic [LANES*LANES*DATA_W-1:0]   a_flat,
  output logic [LANES*LANES*DATA_W-1:0]   b_flat,
  output logic                            full
);

  localparam int ROW_W = LANES * DATA_W;

  logic [2*LANES-1:0] mask;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_row
    logic [ROW_W-1:0] a_row;
    logic [ROW_W-1:0] b_row;
    logic             a_ok;
    logic             b_ok;
    logic             wr_a;
    logic             wr_b;

    // Row index 3 never matches, so such writes fall through untouched.
    assign wr_a = wr_en && !wr_sel && (wr_row == 2'(gi));
    assign wr_b = wr_en &&  wr_sel && (wr_row == 2'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_row <= '0;
        b_row <= '0;
        a_ok  <= 1'b0;
        b_ok  <= 1'b0;
      end else begin
        if (wr_a) begin
          a_row <= wr_data;
          a_ok  <= 1'b1;
        end
        if (wr_b) begin
          b_row <= wr_data;
          b_ok  <= 1'b1;
        end
      end
    end

    assign a_flat[elem_idx(gi, 0)*DATA_W +: ROW_W] = a_row;
    assign b_flat[elem_idx(gi, 0)*DATA_W +: ROW_W] = b_row;
    assign mask[gi]         = a_ok;
    assign mask[LANES + gi] = b_ok;
  end

  assign full = &mask;

endmodule

// File: rtl/systolic_feeder.sv
// Streams stored 3x3 A/B matrices into a systolic array: three beats of
// A columns / B rows, then a flush window and a one-cycle done pulse.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int FLUSH_CYCLES = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    load_sel,
  input  logic [1:0]              load_row,
  input  logic [LANES*DATA_W-1:0] load_data,
  input  logic                    start,
  output logic                    start_err,
  output logic                    busy,
  output logic                    done,
  output logic                    valid_out,
  output logic [LANES*DATA_W-1:0] matrix_a_out,
  output logic [LANES*DATA_W-1:0] matrix_b_out
);

  localparam int CNT_W = (FLUSH_CYCLES > 15) ? $clog2(FLUSH_CYCLES + 1) : 4;
  localparam logic [CNT_W-1:0] FLUSH_LAST = (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] BEATS      = CNT_W'(LANES);

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic                          wr_en;
  logic                          full;
  logic [LANES*LANES*DATA_W-1:0] a_flat;
  logic [LANES*LANES*DATA_W-1:0] b_flat;
  logic [LANES*DATA_W-1:0]       beat_a;
  logic [LANES*DATA_W-1:0]       beat_b;
  int                            beat_idx;

  assign load_ready = rst_n && (state == ST_IDLE) && !start;
  assign wr_en      = load_valid && load_ready;

  feeder_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_sel  (load_sel),
    .wr_row  (load_row),
    .wr_data (load_data),
    .a_flat  (a_flat),
    .b_flat  (b_flat),
    .full    (full)
  );

  // Beat to present next: 0 when launching from IDLE, else the counter value.
  always_comb begin
    beat_idx = 0;
    if (state == ST_STREAM && cnt < BEATS) begin
      beat_idx = int'(cnt);
    end
    beat_a = '0;
    beat_b = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_a[lane_lsb(i, DATA_W) +: DATA_W] = a_flat[lane_lsb(elem_idx(i, beat_idx), DATA_W) +: DATA_W];
      beat_b[lane_lsb(i, DATA_W) +: DATA_W] = b_flat[lane_lsb(elem_idx(beat_idx, i), DATA_W) +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      start_err    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid_out    <= 1'b0;
      matrix_a_out <= '0;
      matrix_b_out <= '0;
    end else begin
      start_err    <= 1'b0;
      done         <= 1'b0;
      valid_out    <= 1'b0;
      matrix_a_out <= '0;
      matrix_b_out <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (full) begin
              state        <= ST_STREAM;
              cnt          <= CNT_W'(1);
              busy         <= 1'b1;
              valid_out    <= 1'b1;
              matrix_a_out <= beat_a;
              matrix_b_out <= beat_b;
            end else begin
              start_err <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (cnt == BEATS) begin
            cnt <= '0;
            if (FLUSH_CYCLES == 0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FLUSH;
            end
          end else begin
            cnt          <= cnt + 1'b1;
            valid_out    <= 1'b1;
            matrix_a_out <= beat_a;
            matrix_b_out <= beat_b;
          end
        end
        ST_FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            cnt   <= '0;
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 4, element width in bits.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 7, idle cycles after the last beat, covering the downstream array latency.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load_valid, input, 1, row-write request.
REQ-006 SHALL have port load_ready, output, 1, row write accepted this cycle when high with load_valid.
REQ-007 SHALL have port load_sel, input, 1, 0 selects matrix A, 1 selects matrix B.
REQ-008 SHALL have port load_row, input, 2, row index 0..2; value 3 is illegal.
REQ-009 SHALL have port load_data, input, 3*DATA_W, row elements; element c in bits [c*DATA_W +: DATA_W].
REQ-010 SHALL have port start, input, 1, request to stream the stored matrices.
REQ-011 SHALL have port start_err, output, 1, one-cycle pulse when start is rejected.
REQ-012 SHALL have port busy, output, 1, high while a run is in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at end of run.
REQ-014 SHALL have port valid_out, output, 1, drives the downstream array valid_in.
REQ-015 SHALL have port matrix_a_out, output, 3*DATA_W, A lanes to the downstream array.
REQ-016 SHALL have port matrix_b_out, output, 3*DATA_W, B lanes to the downstream array.

Function
REQ-017 SHALL hold two 3x3 buffers A[r][c] and B[r][c] plus a 6-bit loaded mask (one bit per A/B row).
REQ-018 SHALL implement the states IDLE, STREAM, FLUSH and DONE.
REQ-019 load_ready SHALL be (state==IDLE) && !start; on acceptance it writes the selected row and sets its mask bit.
REQ-020 An accepted load with load_row==3 SHALL be dropped, leaving the buffers and mask unchanged.
REQ-021 start in IDLE with the mask all ones SHALL transition to STREAM; with any mask bit clear it SHALL stay in IDLE and pulse start_err next cycle.
REQ-022 start outside IDLE SHALL be ignored, with no start_err.
REQ-023 All outputs SHALL be registered; STREAM lasts 3 cycles, beat k = 0,1,2, starting the cycle after start is accepted.
REQ-024 On beat k, matrix_a_out lane i SHALL equal A[i][k] and matrix_b_out lane j SHALL equal B[k][j], with valid_out = 1.
REQ-025 Outside STREAM, valid_out, matrix_a_out and matrix_b_out SHALL be 0.
REQ-026 FLUSH SHALL last FLUSH_CYCLES cycles; FLUSH_CYCLES = 0 skips FLUSH entirely.
REQ-027 DONE SHALL last 1 cycle with done = 1, then return to IDLE.
REQ-028 busy SHALL be 1 in STREAM, FLUSH and DONE, and 0 in IDLE.
REQ-029 The buffers and mask SHALL persist after a run, so re-start is possible without reloading.
REQ-030 A counter of at least 4 bits SHALL sequence STREAM and FLUSH and wrap to 0 on each state exit.

Reset
REQ-031 While rst_n = 0, all outputs SHALL be 0, state SHALL be IDLE, and buffers, mask and counter SHALL be 0.
REQ-032 Reset asserted mid-run SHALL abort the run immediately, with no done pulse; after release the mask is 0 and a reload is required.

Structure
REQ-033 The state encoding, the lane count 3 and the lane-pack/unpack index helpers SHALL live in the shared package systolic_pkg.
REQ-034 The buffers plus mask SHALL be one sub-module, feeder_buf, and the FSM, counter and output registers SHALL stay in the top level.

Verification
REQ-035 The bench SHALL load A = [[1,2,3],[4,5,6],[7,8,9]] and B = identity, then start; it SHALL see valid_out high for exactly 3 cycles with a/b = 741/001, 852/010, 963/100 (hex), then valid_out low.
REQ-036 In the same run, the bench SHALL see busy high for exactly 11 cycles and done high only in the 11th.
REQ-037 The bench SHALL load A fully and B rows 0-1 only, then assert start; it SHALL see start_err pulse once, busy stay 0 and valid_out stay 0.
REQ-038 The bench SHALL assert load_valid and start together in IDLE with a full mask; load_ready SHALL be 0, the buffers unchanged and the stream SHALL use the old data.
REQ-039 The bench SHALL assert rst_n low during beat 1; all outputs SHALL be 0 at once, and after release a start SHALL pulse start_err.
REQ-040 The bench SHALL write load_row = 3 and run with FLUSH_CYCLES = 0; the buffers SHALL be unchanged and done SHALL pulse in the cycle after beat 2.
